guess_judge: RTL and testbench
==============================

# guess_judge

Judging stage of the number-guess game, directly downstream of the target-value register. Latches the 17-bit BCD target at round start, accepts the player's BCD guesses on each submit-button press, and reports higher/lower/equal. Counts attempts and declares win or loss. Outputs drive the LED/7-segment status logic.

## Interface

Parameters:
- MAX_TRIES, default 7: attempts allowed per round, legal range 1..15.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high; clears all state on the next rising edge.
- start  input  1  active-high level, sampled each clock; begins or restarts a round.
- n_value  input  17  target value: [15:0] four BCD digits, [16] ten-thousands digit (0/1).
- guess  input  17  player guess, same encoding as n_value.
- submit_guess  input  1  active-low button level, same polarity as the target-submit button.
- target_hi  output  1  last valid guess was below the target.
- target_lo  output  1  last valid guess was above the target.
- equal  output  1  last valid guess matched the target.
- result_valid  output  1  one-cycle pulse when a judged result updates.
- bad_guess  output  1  one-cycle pulse when a guess is rejected as non-BCD.
- tries  output  4  valid guesses consumed in the current round.
- win  output  1  round won; held.
- lose  output  1  round lost; held.
- busy  output  1  high in ARMED and JUDGE.

## Operation

- The FSM has four states: IDLE, ARMED, JUDGE, DONE.
- Reset forces these values on the next edge:
  - state is IDLE.
  - All outputs are 0.
  - tries is 0.
  - The internal target register is 17'h10000.
  - The submit history register is 1.
- submit press detection:
  - submit_guess is registered once per cycle into `sub_q`.
  - A press is the edge where the registered `sub_q` is 1 and the current submit_guess is 0.
  - Holding the button low yields exactly one press.
- IDLE:
  - On start, latch n_value into the target register.
  - Clear tries, target_hi, target_lo, equal, win and lose.
  - Go to ARMED.
- ARMED:
  - start has the same effect as in IDLE, and takes priority over a press in the same cycle.
  - On a press, latch guess into the guess register.
  - If any BCD nibble of guess is greater than 9, pulse bad_guess, stay in ARMED, and leave tries unchanged.
  - Otherwise go to JUDGE.
- JUDGE (exactly one cycle):
  - Compare the guess and target registers as 17-bit unsigned values. With valid BCD digits this equals the decimal order.
  - Set exactly one of target_hi, target_lo or equal.
  - Increment tries; it saturates at 15.
  - Pulse result_valid.
  - If equal: set win and go to DONE.
  - Else if the new tries equals MAX_TRIES: set lose and go to DONE.
  - Else: go back to ARMED.
- DONE:
  - Hold all outputs.
  - Ignore presses.
  - On start, restart the round as in IDLE.
- Target stability: n_value changes after start do not affect the round in progress.

## Timing

- Press to result:
  - Press sampled at edge t: guess latched, state enters JUDGE.
  - Edge t+1: results, tries, win/lose and result_valid become visible. result_valid is high for cycle t+1..t+2 only.
- bad_guess is high for the single cycle after the rejecting edge t.
- Back-to-back presses: the earliest next press accepted is at edge t+2.
  - The button must be released to 1 for at least one sampled cycle between presses.
- Reset during JUDGE: reset wins, with no result_valid and no tries increment.
- start and reset asserted together: reset wins.
- busy is a registered decode of the state, with zero extra latency.

## Configuration

- GUESS_TRY_LIMIT_EN
  - Defined: MAX_TRIES enforced; lose asserted as described above.
  - Undefined: no attempt limit; lose is tied to 0; tries saturates at 15; the round ends only on equal or start.

## Test plan

- Reset, then start with n_value=17'h01234; press with guess=17'h00999 -> edge t+1: target_hi=1, result_valid pulse, tries=1, win=0.
- Same round: guess=17'h01300 -> target_lo=1, tries=2; then guess=17'h01234 -> equal=1, win=1, state DONE; a further press leaves tries=3 and all outputs unchanged.
- Target 17'h10000, guess 17'h0A000 -> bad_guess pulse, no result_valid, tries stays 0, busy=1.
- With GUESS_TRY_LIMIT_EN and MAX_TRIES=3: three wrong guesses -> lose=1 on the third result, tries=3. Without the macro: same stimulus -> lose=0, round continues, a fourth guess gives tries=4.
- Hold submit_guess low 20 cycles -> exactly one result_valid. Assert start together with a press in ARMED -> round restarts, tries=0, no judge. Assert reset during JUDGE -> all outputs 0 next edge.

Source files
------------

// File: rtl/guess_judge.sv
// Judging stage of the number-guess game: latches a BCD target, judges BCD guesses on
// submit presses, counts attempts and flags win/lose. Optional macro: GUESS_TRY_LIMIT_EN.
module guess_judge #(
   parameter int MAX_TRIES = 7
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [16:0] n_value,
   input  logic [16:0] guess,
   input  logic        submit_guess,
   output logic        target_hi,
   output logic        target_lo,
   output logic        equal,
   output logic        result_valid,
   output logic        bad_guess,
   output logic [3:0]  tries,
   output logic        win,
   output logic        lose,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, ARMED, JUDGE, DONE} state_t;

`ifdef GUESS_TRY_LIMIT_EN
   localparam bit LIMIT_EN = 1'b1;
`else
   localparam bit LIMIT_EN = 1'b0;
`endif
   localparam logic [3:0] LIMIT = 4'(MAX_TRIES);

   state_t      state_reg, state_next;
   logic [16:0] target_reg, target_next;
   logic [16:0] guess_reg, guess_next;
   logic        sub_q;
   logic [3:0]  tries_reg, tries_next, tries_inc;
   logic        hi_reg, hi_next, lo_reg, lo_next, eq_reg, eq_next;
   logic        win_reg, win_next, lose_reg, lose_next;
   logic        rv_reg, rv_next, bad_reg, bad_next;
   logic        busy_reg, busy_next;
   logic        press;
   logic [3:0]  nibble_bad;

   // Bit 16 is a single 0/1 digit and can never be out of range.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_nib
         assign nibble_bad[gi] = (guess[4*gi+3 -: 4] > 4'd9);
      end
   endgenerate

   // The button is active-low; a press is the first low sample after a high one.
   assign press = sub_q & ~submit_guess;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg  <= IDLE;
         target_reg <= 17'h10000;
         guess_reg  <= '0;
         sub_q      <= 1'b1;
         tries_reg  <= '0;
         hi_reg     <= 1'b0;
         lo_reg     <= 1'b0;
         eq_reg     <= 1'b0;
         win_reg    <= 1'b0;
         lose_reg   <= 1'b0;
         rv_reg     <= 1'b0;
         bad_reg    <= 1'b0;
         busy_reg   <= 1'b0;
      end else begin
         state_reg  <= state_next;
         target_reg <= target_next;
         guess_reg  <= guess_next;
         sub_q      <= submit_guess;
         tries_reg  <= tries_next;
         hi_reg     <= hi_next;
         lo_reg     <= lo_next;
         eq_reg     <= eq_next;
         win_reg    <= win_next;
         lose_reg   <= lose_next;
         rv_reg     <= rv_next;
         bad_reg    <= bad_next;
         busy_reg   <= busy_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      target_next = target_reg;
      guess_next  = guess_reg;
      tries_next  = tries_reg;
      hi_next     = hi_reg;
      lo_next     = lo_reg;
      eq_next     = eq_reg;
      win_next    = win_reg;
      lose_next   = lose_reg;
      rv_next     = 1'b0;
      bad_next    = 1'b0;
      tries_inc   = (tries_reg == 4'd15) ? 4'd15 : tries_reg + 4'd1;

      case (state_reg)
         IDLE, DONE: begin
            if (start) begin
               target_next = n_value;
               tries_next  = '0;
               hi_next     = 1'b0;
               lo_next     = 1'b0;
               eq_next     = 1'b0;
               win_next    = 1'b0;
               lose_next   = 1'b0;
               state_next  = ARMED;
            end
         end
         ARMED: begin
            if (start) begin
               target_next = n_value;
               tries_next  = '0;
               hi_next     = 1'b0;
               lo_next     = 1'b0;
               eq_next     = 1'b0;
               win_next    = 1'b0;
               lose_next   = 1'b0;
            end else if (press) begin
               guess_next = guess;
               if (|nibble_bad) bad_next = 1'b1;
               else             state_next = JUDGE;
            end
         end
         JUDGE: begin
            // Plain binary compare matches decimal order for well-formed BCD.
            hi_next    = (guess_reg < target_reg);
            lo_next    = (guess_reg > target_reg);
            eq_next    = (guess_reg == target_reg);
            tries_next = tries_inc;
            rv_next    = 1'b1;
            if (guess_reg == target_reg) begin
               win_next   = 1'b1;
               state_next = DONE;
            end else if (LIMIT_EN && (tries_inc == LIMIT)) begin
               lose_next  = 1'b1;
               state_next = DONE;
            end else begin
               state_next = ARMED;
            end
         end
         default: state_next = IDLE;
      endcase

      busy_next = (state_next == ARMED) || (state_next == JUDGE);
   end

   assign target_hi    = hi_reg;
   assign target_lo    = lo_reg;
   assign equal        = eq_reg;
   assign result_valid = rv_reg;
   assign bad_guess    = bad_reg;
   assign tries        = tries_reg;
   assign win          = win_reg;
   assign lose         = lose_reg;
   assign busy         = busy_reg;

endmodule

// File: tb/tb_guess_judge.sv
// Scoreboard bench for guess_judge: stimulus pushes expected result/bad-guess events,
// a negedge monitor pops and compares them; direct checks cover state between events.
module tb_guess_judge;

   logic        clk = 1'b0;
   logic        reset, start, submit_guess;
   logic [16:0] n_value, guess;
   logic        target_hi, target_lo, equal, result_valid, bad_guess;
   logic [3:0]  tries;
   logic        win, lose, busy;

   int checks = 0;
   int errors = 0;

   // {result_valid, bad_guess, hi, lo, eq, tries[3:0], win, lose}
   logic [10:0] exp_q[$];

   guess_judge #(.MAX_TRIES(3)) dut (
      .clk(clk), .reset(reset), .start(start), .n_value(n_value), .guess(guess),
      .submit_guess(submit_guess), .target_hi(target_hi), .target_lo(target_lo),
      .equal(equal), .result_valid(result_valid), .bad_guess(bad_guess),
      .tries(tries), .win(win), .lose(lose), .busy(busy)
   );

   always #5 clk = ~clk;

`ifdef GUESS_TRY_LIMIT_EN
   localparam bit LIM = 1'b1;
`else
   localparam bit LIM = 1'b0;
`endif

   always @(negedge clk) begin
      if (result_valid || bad_guess) begin
         logic [10:0] act;
         act = {result_valid, bad_guess, target_hi, target_lo, equal, tries, win, lose};
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL event: unexpected output event act=%b", act);
         end else begin
            logic [10:0] e;
            e = exp_q.pop_front();
            if (act !== e) begin
               errors++;
               $display("FAIL event: act={rv,bad,hi,lo,eq,tries,win,lose}=%b exp=%b", act, e);
            end else
               $display("event ok: %b", act);
         end
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: act=%h exp=%h", name, act, exp);
      end else
         $display("check ok %s: %h", name, act);
   endtask

   task automatic do_start(input logic [16:0] n);
      n_value = n; start = 1'b1;
      tick();
      start = 1'b0; n_value = 17'h0ABCD;
   endtask

   task automatic press(input logic [16:0] g);
      guess = g; submit_guess = 1'b0;
      tick();
      submit_guess = 1'b1;
      tick();
   endtask

   function automatic logic [10:0] res(input logic h, l, e, input logic [3:0] t,
                                       input logic w, input logic lo_s);
      return {1'b1, 1'b0, h, l, e, t, w, lo_s};
   endfunction

   initial begin
      reset = 1'b1; start = 1'b0; submit_guess = 1'b1;
      n_value = '0; guess = '0;
      tick(2);
      check("reset_outs", {7'd0, target_hi, target_lo, equal, result_valid, bad_guess,
                           win, lose, busy}, 16'h0);
      check("reset_tries", {12'd0, tries}, 16'd0);
      reset = 1'b0;
      tick();

      do_start(17'h01234);
      check("busy_armed", {15'd0, busy}, 16'd1);
      exp_q.push_back(res(1, 0, 0, 4'd1, 0, 0));
      press(17'h00999);
      exp_q.push_back(res(0, 1, 0, 4'd2, 0, 0));
      press(17'h01300);
      exp_q.push_back(res(0, 0, 1, 4'd3, 1, 0));
      press(17'h01234);
      check("win_held", {15'd0, win}, 16'd1);
      check("busy_done", {15'd0, busy}, 16'd0);
      press(17'h00001);                  // ignored in DONE
      tick(2);
      check("done_hold", {9'd0, tries, target_hi, target_lo, equal}, {9'd0, 4'd3, 3'b001});

      do_start(17'h10000);
      exp_q.push_back({2'b01, 3'b000, 4'd0, 2'b00});
      press(17'h0A000);
      check("bad_tries", {12'd0, tries}, 16'd0);
      check("bad_busy", {15'd0, busy}, 16'd1);

      exp_q.push_back(res(1, 0, 0, 4'd1, 0, 0));
      press(17'h00001);
      exp_q.push_back(res(1, 0, 0, 4'd2, 0, 0));
      press(17'h00002);
      exp_q.push_back(res(1, 0, 0, 4'd3, 0, LIM));
      press(17'h00003);
      check("lose_flag", {15'd0, lose}, {15'd0, LIM});
      if (!LIM) begin
         exp_q.push_back(res(1, 0, 0, 4'd4, 0, 0));
         press(17'h00004);
         check("tries4", {12'd0, tries}, 16'd4);
      end

      do_start(17'h00500);
      exp_q.push_back(res(1, 0, 0, 4'd1, 0, 0));
      guess = 17'h00100; submit_guess = 1'b0;
      tick(20);
      submit_guess = 1'b1;
      tick(2);
      check("hold_tries", {12'd0, tries}, 16'd1);

      n_value = 17'h00700; start = 1'b1; guess = 17'h00001; submit_guess = 1'b0;
      tick();
      start = 1'b0; submit_guess = 1'b1;
      tick(2);
      check("start_prio", {11'd0, tries, target_hi}, 16'd0);
      check("start_busy", {15'd0, busy}, 16'd1);

      exp_q.push_back(res(1, 0, 0, 4'd1, 0, 0));
      press(17'h00001);                  // target 00700 latched by the restart
      guess = 17'h00002; submit_guess = 1'b0;
      tick();                            // enters JUDGE
      submit_guess = 1'b1; reset = 1'b1;
      tick();
      reset = 1'b0;
      check("rst_judge", {3'd0, tries, target_hi, target_lo, equal, result_valid,
                          bad_guess, win, lose, busy}, 16'd0);
      tick(3);

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expected events never seen, exp=0", exp_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
